// File: rtl/apb2axi_pkg.sv
// rtl/apb2axi_pkg.sv - shared widths, directory entry and issue FSM types for the gateway
package apb2axi_pkg;
  localparam int TAG_NUM    = 8;
  localparam int TAG_W      = $clog2(TAG_NUM);
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  is_write;
  } directory_entry_t;

  typedef enum logic [1:0] {
    TXN_IDLE    = 2'd0,
    TXN_ADDR_RD = 2'd1,
    TXN_ADDR_WR = 2'd2
  } txn_state_e;
endpackage

// File: rtl/apb2axi_rsp_tracker.sv
// rtl/apb2axi_rsp_tracker.sv - R/B response handling, per-tag error accumulation, completions
module apb2axi_rsp_tracker
  import apb2axi_pkg::*;
#(
  parameter int TAG_NUM_P = TAG_NUM,
  parameter int TAG_W_P   = TAG_W
) (
  input  logic                  i_pclk,
  input  logic                  i_presetn,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [AXI_ID_W-1:0]   i_rid,
  input  logic [AXI_DATA_W-1:0] i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  input  logic                  i_bvalid,
  input  logic [AXI_ID_W-1:0]   i_bid,
  input  logic [1:0]            i_bresp,
  output logic                  o_rd_valid,
  output logic [TAG_W_P-1:0]    o_rd_tag,
  output logic [AXI_DATA_W-1:0] o_rd_data,
  output logic                  o_rd_last,
  output logic                  o_cpl_valid,
  output logic [TAG_W_P-1:0]    o_cpl_tag,
  output logic                  o_cpl_error,
  output logic                  o_dec
);
  logic [TAG_W_P-1:0]    w_rtag;
  logic [TAG_W_P-1:0]    w_btag;
  logic                  w_r_hs;
  logic                  w_r_done;
  logic                  w_b_hs;
  logic                  w_unused_bits;
  logic [TAG_NUM_P-1:0]  r_err_acc;
  logic                  r_rd_valid;
  logic [TAG_W_P-1:0]    r_rd_tag;
  logic [AXI_DATA_W-1:0] r_rd_data;
  logic                  r_rd_last;
  logic                  r_cpl_valid;
  logic [TAG_W_P-1:0]    r_cpl_tag;
  logic                  r_cpl_error;

  // IDs carry the tag zero-extended, so only the low bits are meaningful.
  assign w_rtag        = i_rid[TAG_W_P-1:0];
  assign w_btag        = i_bid[TAG_W_P-1:0];
  assign w_unused_bits = ^{i_rid[AXI_ID_W-1:TAG_W_P], i_bid[AXI_ID_W-1:TAG_W_P], i_rresp[0], i_bresp[0]};

  // A final R beat yields to B so the single completion port never sees two at once.
  assign o_rready = !(i_bvalid && i_rvalid && i_rlast);
  assign w_r_hs   = i_rvalid && o_rready;
  assign w_r_done = w_r_hs && i_rlast;
  assign w_b_hs   = i_bvalid;
  assign o_dec    = w_r_done || w_b_hs;

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_err_acc   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_tag    <= '0;
      r_rd_data   <= '0;
      r_rd_last   <= 1'b0;
      r_cpl_valid <= 1'b0;
      r_cpl_tag   <= '0;
      r_cpl_error <= 1'b0;
    end else begin
      r_rd_valid  <= w_r_hs;
      r_cpl_valid <= w_b_hs || w_r_done;
      if (w_r_hs) begin
        r_rd_tag  <= w_rtag;
        r_rd_data <= i_rdata;
        r_rd_last <= i_rlast;
        if (i_rlast)         r_err_acc[w_rtag] <= 1'b0;
        else if (i_rresp[1]) r_err_acc[w_rtag] <= 1'b1;
      end
      if (w_b_hs) begin
        r_cpl_tag   <= w_btag;
        r_cpl_error <= i_bresp[1];
      end else if (w_r_done) begin
        r_cpl_tag   <= w_rtag;
        r_cpl_error <= r_err_acc[w_rtag] | i_rresp[1];
      end
    end
  end

  assign o_rd_valid  = r_rd_valid;
  assign o_rd_tag    = r_rd_tag;
  assign o_rd_data   = r_rd_data;
  assign o_rd_last   = r_rd_last;
  assign o_cpl_valid = r_cpl_valid;
  assign o_cpl_tag   = r_cpl_tag;
  assign o_cpl_error = r_cpl_error;

  a_one_cpl: assert property (@(posedge i_pclk) disable iff (!i_presetn) !(w_b_hs && w_r_done));
endmodule

// File: rtl/apb2axi_txn_mgr.sv
// rtl/apb2axi_txn_mgr.sv - pops pending directory entries, issues AXI AR/AW, tracks in-flight count
module apb2axi_txn_mgr
  import apb2axi_pkg::*;
#(
  parameter int TAG_NUM_P         = TAG_NUM,
  parameter int TAG_W_P           = TAG_W,
  parameter int MAX_OUTSTANDING_P = 4,
  localparam int CNT_W            = $clog2(MAX_OUTSTANDING_P + 1)
) (
  input  logic                  i_pclk,
  input  logic                  i_presetn,
  input  logic                  i_pending_valid,
  input  directory_entry_t      i_pending_entry,
  input  logic [TAG_W_P-1:0]    i_pending_tag,
  output logic                  o_pending_pop,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  output logic [AXI_ADDR_W-1:0] o_araddr,
  output logic [7:0]            o_arlen,
  output logic [2:0]            o_arsize,
  output logic [1:0]            o_arburst,
  output logic [AXI_ID_W-1:0]   o_arid,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [AXI_ADDR_W-1:0] o_awaddr,
  output logic [7:0]            o_awlen,
  output logic [2:0]            o_awsize,
  output logic [1:0]            o_awburst,
  output logic [AXI_ID_W-1:0]   o_awid,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [AXI_ID_W-1:0]   i_rid,
  input  logic [AXI_DATA_W-1:0] i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  input  logic [AXI_ID_W-1:0]   i_bid,
  input  logic [1:0]            i_bresp,
  output logic                  o_rd_valid,
  output logic [TAG_W_P-1:0]    o_rd_tag,
  output logic [AXI_DATA_W-1:0] o_rd_data,
  output logic                  o_rd_last,
  output logic                  o_cpl_valid,
  output logic [TAG_W_P-1:0]    o_cpl_tag,
  output logic                  o_cpl_error,
  output logic [CNT_W-1:0]      o_outstanding
);
  txn_state_e      r_state;
  logic [CNT_W-1:0] r_outstanding;
  logic            w_full;
  logic            w_pop;
  logic            w_dec;

  assign w_full        = r_outstanding >= CNT_W'(MAX_OUTSTANDING_P);
  // Gated by reset so the strobe is low immediately when reset asserts.
  assign w_pop         = i_presetn && (r_state == TXN_IDLE) && i_pending_valid && !w_full;
  assign o_pending_pop = w_pop;
  assign o_bready      = 1'b1;
  assign o_outstanding = r_outstanding;

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_state   <= TXN_IDLE;
      o_arvalid <= 1'b0;
      o_araddr  <= '0;
      o_arlen   <= '0;
      o_arsize  <= '0;
      o_arburst <= '0;
      o_arid    <= '0;
      o_awvalid <= 1'b0;
      o_awaddr  <= '0;
      o_awlen   <= '0;
      o_awsize  <= '0;
      o_awburst <= '0;
      o_awid    <= '0;
    end else begin
      case (r_state)
        TXN_IDLE: begin
          if (w_pop) begin
            if (i_pending_entry.is_write) begin
              r_state   <= TXN_ADDR_WR;
              o_awvalid <= 1'b1;
              o_awaddr  <= i_pending_entry.addr;
              o_awlen   <= i_pending_entry.len;
              o_awsize  <= i_pending_entry.size;
              o_awburst <= i_pending_entry.burst;
              o_awid    <= AXI_ID_W'(i_pending_tag);
            end else begin
              r_state   <= TXN_ADDR_RD;
              o_arvalid <= 1'b1;
              o_araddr  <= i_pending_entry.addr;
              o_arlen   <= i_pending_entry.len;
              o_arsize  <= i_pending_entry.size;
              o_arburst <= i_pending_entry.burst;
              o_arid    <= AXI_ID_W'(i_pending_tag);
            end
          end
        end
        TXN_ADDR_RD: begin
          if (i_arready) begin
            o_arvalid <= 1'b0;
            r_state   <= TXN_IDLE;
          end
        end
        TXN_ADDR_WR: begin
          if (i_awready) begin
            o_awvalid <= 1'b0;
            r_state   <= TXN_IDLE;
          end
        end
        default: r_state <= TXN_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn)                                     r_outstanding <= '0;
    else if (w_pop && !w_dec)                           r_outstanding <= r_outstanding + CNT_W'(1);
    else if (w_dec && !w_pop && r_outstanding != '0)    r_outstanding <= r_outstanding - CNT_W'(1);
  end

  apb2axi_rsp_tracker #(
    .TAG_NUM_P (TAG_NUM_P),
    .TAG_W_P   (TAG_W_P)
  ) u_rsp_tracker (
    .i_pclk      (i_pclk),
    .i_presetn   (i_presetn),
    .i_rvalid    (i_rvalid),
    .o_rready    (o_rready),
    .i_rid       (i_rid),
    .i_rdata     (i_rdata),
    .i_rresp     (i_rresp),
    .i_rlast     (i_rlast),
    .i_bvalid    (i_bvalid),
    .i_bid       (i_bid),
    .i_bresp     (i_bresp),
    .o_rd_valid  (o_rd_valid),
    .o_rd_tag    (o_rd_tag),
    .o_rd_data   (o_rd_data),
    .o_rd_last   (o_rd_last),
    .o_cpl_valid (o_cpl_valid),
    .o_cpl_tag   (o_cpl_tag),
    .o_cpl_error (o_cpl_error),
    .o_dec       (w_dec)
  );

  a_ar_stable: assert property (@(posedge i_pclk) disable iff (!i_presetn)
    (o_arvalid && !i_arready) |=> (o_arvalid && $stable({o_araddr, o_arlen, o_arsize, o_arburst, o_arid})));
  a_aw_stable: assert property (@(posedge i_pclk) disable iff (!i_presetn)
    (o_awvalid && !i_awready) |=> (o_awvalid && $stable({o_awaddr, o_awlen, o_awsize, o_awburst, o_awid})));
  a_no_underflow: assert property (@(posedge i_pclk) disable iff (!i_presetn)
    !(w_dec && !w_pop && r_outstanding == '0));
endmodule

// File: tb/tb_apb2axi_txn_mgr.sv
// tb/tb_apb2axi_txn_mgr.sv - scoreboard bench for apb2axi_txn_mgr
module tb_apb2axi_txn_mgr;
  import apb2axi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  i_pending_valid;
  directory_entry_t      i_pending_entry;
  logic [TAG_W-1:0]      i_pending_tag;
  logic                  o_pending_pop;
  logic                  o_arvalid, i_arready;
  logic [AXI_ADDR_W-1:0] o_araddr;
  logic [7:0]            o_arlen;
  logic [2:0]            o_arsize;
  logic [1:0]            o_arburst;
  logic [AXI_ID_W-1:0]   o_arid;
  logic                  o_awvalid, i_awready;
  logic [AXI_ADDR_W-1:0] o_awaddr;
  logic [7:0]            o_awlen;
  logic [2:0]            o_awsize;
  logic [1:0]            o_awburst;
  logic [AXI_ID_W-1:0]   o_awid;
  logic                  i_rvalid, o_rready, i_rlast;
  logic [AXI_ID_W-1:0]   i_rid;
  logic [AXI_DATA_W-1:0] i_rdata;
  logic [1:0]            i_rresp;
  logic                  i_bvalid, o_bready;
  logic [AXI_ID_W-1:0]   i_bid;
  logic [1:0]            i_bresp;
  logic                  o_rd_valid, o_rd_last;
  logic [TAG_W-1:0]      o_rd_tag;
  logic [AXI_DATA_W-1:0] o_rd_data;
  logic                  o_cpl_valid, o_cpl_error;
  logic [TAG_W-1:0]      o_cpl_tag;
  logic [2:0]            o_outstanding;

  apb2axi_txn_mgr #(.MAX_OUTSTANDING_P(4)) dut (
    .i_pclk(clk), .i_presetn(rst_n),
    .i_pending_valid(i_pending_valid), .i_pending_entry(i_pending_entry),
    .i_pending_tag(i_pending_tag), .o_pending_pop(o_pending_pop),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr), .o_arlen(o_arlen),
    .o_arsize(o_arsize), .o_arburst(o_arburst), .o_arid(o_arid),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr), .o_awlen(o_awlen),
    .o_awsize(o_awsize), .o_awburst(o_awburst), .o_awid(o_awid),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rid(i_rid), .i_rdata(i_rdata),
    .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bid(i_bid), .i_bresp(i_bresp),
    .o_rd_valid(o_rd_valid), .o_rd_tag(o_rd_tag), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
    .o_cpl_valid(o_cpl_valid), .o_cpl_tag(o_cpl_tag), .o_cpl_error(o_cpl_error),
    .o_outstanding(o_outstanding)
  );

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [AXI_ID_W-1:0]   id;
  } addr_t;
  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [AXI_DATA_W-1:0] data;
    logic                  last;
  } rd_t;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             err;
  } cpl_t;

  addr_t exp_ar[$];
  addr_t exp_aw[$];
  rd_t   exp_rd[$];
  cpl_t  exp_cpl[$];
  addr_t ea;
  rd_t   er;
  cpl_t  ec;
  int checks = 0;
  int failures = 0;
  int pop_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=output_seen required=nothing_queued", name);
  endtask

  // Monitor: every DUT output event pops and compares against the queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_pending_pop) pop_cnt++;
      if (o_arvalid && i_arready) begin
        if (exp_ar.size() == 0) unexpected("ar");
        else begin
          ea = exp_ar.pop_front();
          check("ar_fields", {o_araddr, o_arlen, o_arsize, o_arburst, o_arid}, ea);
        end
      end
      if (o_awvalid && i_awready) begin
        if (exp_aw.size() == 0) unexpected("aw");
        else begin
          ea = exp_aw.pop_front();
          check("aw_fields", {o_awaddr, o_awlen, o_awsize, o_awburst, o_awid}, ea);
        end
      end
      if (o_rd_valid) begin
        if (exp_rd.size() == 0) unexpected("rd");
        else begin
          er = exp_rd.pop_front();
          check("rd_beat", {o_rd_tag, o_rd_data, o_rd_last}, er);
        end
      end
      if (o_cpl_valid) begin
        if (exp_cpl.size() == 0) unexpected("cpl");
        else begin
          ec = exp_cpl.pop_front();
          check("cpl", {o_cpl_tag, o_cpl_error}, ec);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int tag, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic wr);
    i_pending_valid = 1'b1;
    i_pending_entry = '{addr: addr, len: len, size: size, burst: 2'b01, is_write: wr};
    i_pending_tag   = TAG_W'(tag);
  endtask

  task automatic issue(input int tag, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic wr);
    if (wr) exp_aw.push_back('{addr, len, size, 2'b01, AXI_ID_W'(tag)});
    else    exp_ar.push_back('{addr, len, size, 2'b01, AXI_ID_W'(tag)});
    present(tag, addr, len, size, wr);
    tick();
    i_pending_valid = 1'b0;
    tick();
  endtask

  task automatic r_beat(input int tag, input logic [31:0] data, input logic [1:0] resp, input logic last);
    exp_rd.push_back('{TAG_W'(tag), data, last});
    i_rvalid = 1'b1; i_rid = AXI_ID_W'(tag); i_rdata = data; i_rresp = resp; i_rlast = last;
    tick();
    i_rvalid = 1'b0; i_rlast = 1'b0;
  endtask

  // Directory model: head entry advances by one each time a pop is seen.
  task automatic hold(input int n, input int base);
    int k;
    for (int c = 0; c < n; c++) begin
      k = pop_cnt - base;
      present(k, 32'h4000 + 32'(k) * 32'h100, 8'd0, 3'd2, 1'b0);
      tick();
    end
  endtask

  int base;

  initial begin
    i_pending_valid = 0; i_pending_entry = '0; i_pending_tag = '0;
    i_arready = 1; i_awready = 1;
    i_rvalid = 0; i_rid = '0; i_rdata = '0; i_rresp = 2'b00; i_rlast = 0;
    i_bvalid = 0; i_bid = '0; i_bresp = 2'b00;
    repeat (2) tick();
    check("rst_arvalid", o_arvalid, 0);
    check("rst_awvalid", o_awvalid, 0);
    check("rst_pop", o_pending_pop, 0);
    check("rst_cpl_valid", o_cpl_valid, 0);
    check("rst_rd_valid", o_rd_valid, 0);
    check("rst_outstanding", o_outstanding, 0);
    check("rst_rready", o_rready, 1);
    check("rst_bready", o_bready, 1);
    rst_n = 1'b1;
    tick();

    // Single read, 4 OKAY beats
    base = pop_cnt;
    exp_ar.push_back('{32'h1000, 8'd3, 3'd2, 2'b01, 4'd2});
    present(2, 32'h1000, 8'd3, 3'd2, 1'b0);
    @(negedge clk);
    check("t1_pop_strobe", o_pending_pop, 1);
    tick();
    i_pending_valid = 1'b0;
    check("t1_outstanding_1", o_outstanding, 1);
    check("t1_pop_after", o_pending_pop, 0);
    tick(); tick();
    check("t1_pop_count", pop_cnt - base, 1);
    exp_cpl.push_back('{3'd2, 1'b0});
    r_beat(2, 32'hA0, RESP_OKAY, 0);
    r_beat(2, 32'hA1, RESP_OKAY, 0);
    r_beat(2, 32'hA2, RESP_EXOKAY, 0);
    r_beat(2, 32'hA3, RESP_OKAY, 1);
    check("t1_outstanding_0", o_outstanding, 0);
    tick();

    // Write with AW backpressure, SLVERR response
    i_awready = 1'b0;
    base = pop_cnt;
    exp_aw.push_back('{32'h2000, 8'd7, 3'd3, 2'b01, 4'd5});
    present(5, 32'h2000, 8'd7, 3'd3, 1'b1);
    tick();
    i_pending_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t2_awvalid_held", o_awvalid, 1);
      check("t2_aw_stable", {o_awaddr, o_awlen, o_awsize, o_awburst, o_awid},
            {32'h2000, 8'd7, 3'd3, 2'b01, 4'd5});
    end
    check("t2_pop_count", pop_cnt - base, 1);
    i_awready = 1'b1;
    tick();
    check("t2_awvalid_drop", o_awvalid, 0);
    exp_cpl.push_back('{3'd5, 1'b1});
    i_bvalid = 1'b1; i_bid = 4'd5; i_bresp = RESP_SLVERR;
    tick();
    i_bvalid = 1'b0; i_bresp = RESP_OKAY;
    check("t2_outstanding_0", o_outstanding, 0);
    tick();

    // Error accumulation, then cleared for tag reuse
    issue(1, 32'h3000, 8'd2, 3'd2, 1'b0);
    exp_cpl.push_back('{3'd1, 1'b1});
    r_beat(1, 32'hB0, RESP_OKAY, 0);
    r_beat(1, 32'hB1, RESP_SLVERR, 0);
    r_beat(1, 32'hB2, RESP_OKAY, 1);
    tick();
    issue(1, 32'h3100, 8'd0, 3'd2, 1'b0);
    exp_cpl.push_back('{3'd1, 1'b0});
    r_beat(1, 32'hC0, RESP_OKAY, 1);
    tick();

    // Outstanding limit with 6 pending reads
    base = pop_cnt;
    for (int k = 0; k < 4; k++)
      exp_ar.push_back('{32'h4000 + 32'(k) * 32'h100, 8'd0, 3'd2, 2'b01, AXI_ID_W'(k)});
    hold(14, base);
    check("t4_pop_count_4", pop_cnt - base, 4);
    check("t4_outstanding_full", o_outstanding, 4);
    check("t4_pop_held_low", o_pending_pop, 0);
    exp_ar.push_back('{32'h4400, 8'd0, 3'd2, 2'b01, 4'd4});
    exp_rd.push_back('{3'd0, 32'hD0, 1'b1});
    exp_cpl.push_back('{3'd0, 1'b0});
    i_rvalid = 1'b1; i_rid = 4'd0; i_rdata = 32'hD0; i_rresp = RESP_OKAY; i_rlast = 1'b1;
    hold(1, base);
    i_rvalid = 1'b0; i_rlast = 1'b0;
    hold(10, base);
    check("t4_pop_count_5", pop_cnt - base, 5);
    check("t4_outstanding_refull", o_outstanding, 4);
    i_pending_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      exp_cpl.push_back('{TAG_W'(k), 1'b0});
      r_beat(k, 32'hD0 + 32'(k), RESP_OKAY, 1);
    end
    tick();
    check("t4_outstanding_drained", o_outstanding, 0);

    // B and final R collide: B completes first
    issue(3, 32'h5000, 8'd1, 3'd2, 1'b1);
    issue(4, 32'h5100, 8'd0, 3'd2, 1'b0);
    exp_cpl.push_back('{3'd3, 1'b0});
    exp_cpl.push_back('{3'd4, 1'b0});
    exp_rd.push_back('{3'd4, 32'hE4, 1'b1});
    i_bvalid = 1'b1; i_bid = 4'd3; i_bresp = RESP_OKAY;
    i_rvalid = 1'b1; i_rid = 4'd4; i_rdata = 32'hE4; i_rresp = RESP_OKAY; i_rlast = 1'b1;
    @(negedge clk);
    check("t5_rready_blocked", o_rready, 0);
    tick();
    i_bvalid = 1'b0;
    check("t5_first_cpl", {o_cpl_valid, o_cpl_tag}, {1'b1, 3'd3});
    @(negedge clk);
    check("t5_rready_free", o_rready, 1);
    tick();
    i_rvalid = 1'b0; i_rlast = 1'b0;
    check("t5_second_cpl", {o_cpl_valid, o_cpl_tag}, {1'b1, 3'd4});
    tick();
    check("t5_outstanding_0", o_outstanding, 0);

    // Asynchronous reset while AW is stalled
    i_awready = 1'b0;
    present(6, 32'h6000, 8'd1, 3'd2, 1'b1);
    tick();
    i_pending_valid = 1'b0;
    tick();
    check("t6_awvalid_before", o_awvalid, 1);
    #3;
    rst_n = 1'b0;
    present(7, 32'h7000, 8'd0, 3'd2, 1'b0);
    #1;
    check("t6_awvalid_rst", o_awvalid, 0);
    check("t6_pop_rst", o_pending_pop, 0);
    check("t6_cpl_rst", o_cpl_valid, 0);
    check("t6_outstanding_rst", o_outstanding, 0);
    i_pending_valid = 1'b0;
    i_awready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    base = pop_cnt;
    issue(7, 32'h7000, 8'd0, 3'd2, 1'b0);
    check("t6_idle_pop", pop_cnt - base, 1);
    check("t6_outstanding_1", o_outstanding, 1);
    exp_cpl.push_back('{3'd7, 1'b0});
    r_beat(7, 32'hF7, RESP_DECERR & 2'b01, 1);
    tick(); tick();
    check("t6_outstanding_0", o_outstanding, 0);

    check("end_ar_queue", exp_ar.size(), 0);
    check("end_aw_queue", exp_aw.size(), 0);
    check("end_rd_queue", exp_rd.size(), 0);
    check("end_cpl_queue", exp_cpl.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
